// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port among
// N producers. One producer is granted at a time for up to Burst beats; the
// FIFO full flag stalls the burst without ending it.
//
// Handshake: producer i offers a word whenever req[i] is high. A word is
// transferred (a "beat") on a clock edge where grant[i] && req[i] && !full.
// That is the same condition that raises w_en. The producer must hold its
// data slice stable until that edge and present the next word after it.
// Dropping req[i] while granted releases the grant on that edge, with no beat.
module fifo_wr_arbiter #(
  parameter int Width = 8,
  parameter int N     = 4,
  parameter int Burst = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N*Width-1:0]     data_in,
  input  logic                   full,
  output logic [N-1:0]           grant,
  output logic                   w_en,
  output logic [Width-1:0]       wr_data,
  output logic                   busy,
  output logic                   dbg_state,
  output logic [$clog2(N)-1:0]   dbg_last
);

  localparam int LW = $clog2(N);
  localparam int CW = $clog2(Burst + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e          state_q;
  logic [N-1:0]    grant_q;
  logic [LW-1:0]   gidx_q;
  logic [LW-1:0]   last_q;
  logic [CW-1:0]   cnt_q;

  logic [LW-1:0]   win_d;
  logic [N-1:0]    one_hot_d;
  logic [LW-1:0]   cand;
  logic            found;
  logic            req_g;
  logic [Width-1:0] data_g;

  // Round-robin winner: first requester after last_q, wrapping modulo N
  always_comb begin
    win_d = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = LW'((int'(last_q) + k) % N);
      if (!found && req[cand]) begin
        win_d = cand;
        found = 1'b1;
      end
    end
  end

  // One-hot form of the winner, loaded into grant on arbitration
  always_comb begin
    one_hot_d = '0;
    for (int i = 0; i < N; i++) begin
      one_hot_d[i] = (win_d == LW'(i));
    end
  end

  // Select the granted producer's request and data slice
  always_comb begin
    req_g  = 1'b0;
    data_g = '0;
    for (int i = 0; i < N; i++) begin
      if (gidx_q == LW'(i)) begin
        req_g  = req[i];
        data_g = data_in[i*Width +: Width];
      end
    end
  end

  // Arbitration FSM: IDLE picks a winner, BURST counts beats until the
  // burst limit or until the granted producer drops its request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      last_q  <= LW'(N - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= BURST;
            grant_q <= one_hot_d;
            gidx_q  <= win_d;
            cnt_q   <= '0;
          end
        end
        BURST: begin
          if (!req_g) begin
            // early release: no beat on this edge
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= gidx_q;
            cnt_q   <= '0;
          end else if (!full) begin
            if (cnt_q == CW'(Burst - 1)) begin
              state_q <= IDLE;
              grant_q <= '0;
              last_q  <= gidx_q;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign busy      = (state_q == BURST);
  assign grant     = grant_q;
  // reset suppresses the write on the reset edge itself
  assign w_en      = busy && req_g && !full && !rst;
  assign wr_data   = busy ? data_g : '0;
  assign dbg_state = (state_q == BURST);
  assign dbg_last  = last_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter
// against a transaction-level round-robin model, plus a small N=2/Burst=1
// instance with a fixed expected grant pattern.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int BURST = 4;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req;
  logic [N*W-1:0]  data_in;
  logic            full;
  logic [N-1:0]    grant;
  logic            w_en;
  logic [W-1:0]    wr_data;
  logic            busy;
  logic            dbg_state;
  logic [1:0]      dbg_last;

  fifo_wr_arbiter #(.Width(W), .N(N), .Burst(BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .full(full),
    .grant(grant), .w_en(w_en), .wr_data(wr_data), .busy(busy),
    .dbg_state(dbg_state), .dbg_last(dbg_last)
  );

  // second instance: two producers, single-beat bursts
  logic            rst2;
  logic [1:0]      req2;
  logic [15:0]     data2;
  logic            full2;
  logic [1:0]      grant2;
  logic            w_en2;
  logic [W-1:0]    wr_data2;
  logic            busy2;
  logic            dbg_state2;
  logic [0:0]      dbg_last2;

  fifo_wr_arbiter #(.Width(W), .N(2), .Burst(1)) dut2 (
    .clk(clk), .rst(rst2), .req(req2), .data_in(data2), .full(full2),
    .grant(grant2), .w_en(w_en2), .wr_data(wr_data2), .busy(busy2),
    .dbg_state(dbg_state2), .dbg_last(dbg_last2)
  );

  // scoreboard and counters
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_wr     = 0;
  int gorder[$];
  logic [N-1:0] prev_grant = '0;

  // producer state: word index per producer, advanced after each accepted beat
  int           word[N];
  logic [N-1:0] adv = '0;

  // reference model: owner (-1 when idle), beats done, last granted index
  int m_owner = -1;
  int m_beats = 0;
  int m_last  = N - 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pdata(input int i);
    return 8'(8'hA0 + 16 * i + (word[i] % 16));
  endfunction

  // driver + checker for one clock cycle: inputs change at negedge,
  // outputs are sampled 1 time unit later, model advances for the next edge
  task automatic drive_cycle(input logic [N-1:0] r, input logic f, input logic rs);
    logic [N-1:0] exp_grant;
    logic         exp_we;
    logic [W-1:0] exp_wr;
    @(negedge clk);
    for (int i = 0; i < N; i++) if (adv[i]) word[i]++;
    req  = r;
    full = f;
    rst  = rs;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = pdata(i);
    #1;
    exp_grant = (m_owner < 0) ? '0 : 4'(1 << m_owner);
    exp_we    = (m_owner >= 0) && r[m_owner] && !f && !rs;
    exp_wr    = (m_owner >= 0) ? pdata(m_owner) : 8'h00;
    check_eq("grant",   32'(grant),   32'(exp_grant));
    check_eq("busy",    32'(busy),    32'(m_owner >= 0));
    check_eq("w_en",    32'(w_en),    32'(exp_we));
    check_eq("wr_data", 32'(wr_data), 32'(exp_wr));
    check_eq("last",    32'(dbg_last), 32'(m_last));
    if (exp_we) exp_q.push_back(exp_wr);
    if (w_en === 1'b1) begin
      n_wr++;
      check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_eq("sb_data", 32'(wr_data), 32'(exp_q.pop_front()));
    end
    if (grant != '0 && prev_grant == '0)
      for (int i = 0; i < N; i++) if (grant[i]) gorder.push_back(i);
    prev_grant = grant;
    for (int i = 0; i < N; i++) adv[i] = grant[i] && r[i] && !f && !rs;
    // model step, straight from the arbitration rules
    if (rs) begin
      m_owner = -1; m_beats = 0; m_last = N - 1;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (r[c]) begin
          m_owner = c; m_beats = 0;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_last = m_owner; m_owner = -1;
    end else if (!f) begin
      m_beats++;
      if (m_beats == BURST) begin
        m_last = m_owner; m_owner = -1;
      end
    end
  endtask

  initial begin
    int exp_order[6];
    logic [N-1:0] rr;
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) word[i] = 0;
    rst = 1'b1; req = '0; full = 1'b0; data_in = '0;
    rst2 = 1'b1; req2 = '0; full2 = 1'b0; data2 = 16'hB1B0;
    repeat (2) @(posedge clk);

    // reset state, then single producer streaming A0..A3 and regrant
    drive_cycle(4'b0000, 1'b0, 1'b1);
    check_eq("rst_grant", 32'(grant), 32'd0);
    n_wr = 0;
    repeat (12) drive_cycle(4'b0001, 1'b0, 1'b0);
    check_eq("p0_writes", 32'(n_wr), 32'd9);

    // all producers streaming: round-robin order
    drive_cycle(4'b0000, 1'b0, 1'b1);
    gorder.delete();
    repeat (32) drive_cycle(4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)
      check_eq("rr_order", (k < gorder.size()) ? 32'(gorder[k]) : 32'd99, 32'(exp_order[k]));

    // full stall on producer 2 after its second beat
    drive_cycle(4'b0000, 1'b0, 1'b1);
    n_wr = 0;
    drive_cycle(4'b0100, 1'b0, 1'b0);
    repeat (2) drive_cycle(4'b0100, 1'b0, 1'b0);
    repeat (3) drive_cycle(4'b0100, 1'b1, 1'b0);
    repeat (2) drive_cycle(4'b0100, 1'b0, 1'b0);
    drive_cycle(4'b0000, 1'b0, 1'b0);
    check_eq("stall_writes", 32'(n_wr), 32'd4);

    // early release by producer 1, then producer 2 wins over producer 0
    drive_cycle(4'b0000, 1'b0, 1'b1);
    n_wr = 0;
    repeat (3) drive_cycle(4'b0110, 1'b0, 1'b0);
    drive_cycle(4'b0101, 1'b0, 1'b0);
    drive_cycle(4'b0101, 1'b0, 1'b0);
    check_eq("er_writes", 32'(n_wr), 32'd2);
    check_eq("er_last", 32'(dbg_last), 32'd1);
    drive_cycle(4'b0101, 1'b0, 1'b0);
    check_eq("er_grant", 32'(grant), 32'b0100);
    drive_cycle(4'b0000, 1'b0, 1'b0);

    // reset mid-burst at beat 2
    drive_cycle(4'b0000, 1'b0, 1'b1);
    repeat (2) drive_cycle(4'b1111, 1'b0, 1'b0);
    drive_cycle(4'b1111, 1'b0, 1'b1);
    check_eq("rst_w_en", 32'(w_en), 32'd0);
    drive_cycle(4'b1111, 1'b0, 1'b0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    drive_cycle(4'b1111, 1'b0, 1'b0);
    check_eq("rst_regrant", 32'(grant), 32'b0001);

    // randomized traffic with stalls and occasional reset
    rr = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) < 2) rr[i] = ~rr[i];
      drive_cycle(rr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    end
    drive_cycle(4'b0000, 1'b0, 1'b1);
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    // N=2, Burst=1: grants alternate with an idle cycle between
    @(negedge clk);
    rst2 = 1'b0;
    req2 = 2'b11;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      check_eq("n2_grant", 32'(grant2),
               (c % 2 == 0) ? ((c % 4 == 0) ? 32'b01 : 32'b10) : 32'd0);
      check_eq("n2_w_en", 32'(w_en2), 32'(c % 2 == 0));
      check_eq("n2_data", 32'(wr_data2),
               (c % 4 == 0) ? 32'hB0 : ((c % 4 == 2) ? 32'hB1 : 32'h0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO's write port among N producers. Each producer raises a request and presents data. The arbiter grants one producer at a time for a bounded burst and drives the FIFO `w_en`/`data_in`, stalling on FIFO `full`. It sits directly in front of the 16 x 8 synchronous FIFO.

## Interface
- `Width`, 8, data width per producer and of the FIFO write port
- `N`, 4, number of producers (2..8)
- `Burst`, 4, maximum beats per grant (1..15)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req`  in  N  per-producer request; held high while the producer has data
- `data_in`  in  N*Width  producer data; producer i uses bits [i*Width +: Width]
- `full`  in  1  FIFO full flag
- `grant`  out  N  registered one-hot grant; all zeros when idle
- `w_en`  out  1  FIFO write enable (combinational)
- `wr_data`  out  Width  FIFO write data (combinational)
- `busy`  out  1  high while in BURST

## Operation
- States:
  - IDLE: `grant`=0.
  - BURST: exactly one `grant` bit set.
- Round-robin pointer `last` (log2 N bits) holds the index of the last granted producer.
- IDLE -> BURST:
  - Transition happens on an edge where `req`≠0.
  - The winner is the first set `req` bit searching `last+1, last+2, …`, wrapping modulo N.
  - On that edge: `grant` ← one-hot(winner), beat counter ← 0.
- Beat: an edge in BURST where `req[g] && !full`, g being the granted index.
  - Write qualifier: `w_en = busy && req[g] && !full && !rst`.
  - `wr_data = data_in[g]` when `busy`, else 0.
  - The beat counter increments on each beat.
- BURST -> IDLE happens on the edge where either of these holds:
  - a beat occurs with counter = `Burst-1` (last beat), or
  - `req[g]`=0 (early release; no beat on that edge).
  - On exit: `last` ← g, `grant` ← 0.
- `full` high in BURST: no beat, counter holds, grant holds. A full FIFO never ends a burst by itself.
- Requests from non-granted producers are ignored until the next IDLE arbitration.
- Producer contract:
  - hold `data_in` slice stable while `req[i] && grant[i]`;
  - advance to the next word after each edge where `grant[i] && req[i] && !full`;
  - `req` may drop at any time.
- `data_in`/`req` of non-granted producers never reach the FIFO.

## Timing
- Reset values: `grant`=0, `busy`=0, `w_en`=0, `wr_data`=0, state IDLE, counter 0, `last`=N-1 (producer 0 wins first).
- `rst` is sampled on the clock edge only.
  - While `rst`=1, `w_en` is forced 0 combinationally.
  - A reset mid-burst aborts the burst and writes nothing on the reset edge.
- Arbitration latency:
  - `req` high before edge k in IDLE -> `grant` high after edge k.
  - First write lands on edge k+1 if `!full`.
- Uninterrupted burst of `Burst`=4: writes on edges k+1..k+4; `grant` low after edge k+4.
  - Next arbitration on edge k+5; next grant visible after k+5.
  - One idle cycle between grants, always.
- Early release: `req[g]` low before edge m -> `grant` low after edge m; `w_en` is already 0 during that cycle.
- Counter width is ceil(log2(Burst+1)) bits; it never wraps within a burst.
- `last` wraps N-1 -> 0.

## Test plan
- Reset, then `req`=0001, FIFO empty, data 0xA0..0xA3:
  - `grant`=0001 one cycle after `req`;
  - exactly 4 writes 0xA0..0xA3 on consecutive edges;
  - `grant`=0 after the 4th, then regranted after one idle cycle.
- `req`=1111 held, all producers streaming:
  - grant order 0,1,2,3,0,1;
  - each grant yields 4 writes;
  - one idle cycle between grants;
  - no write from a non-granted producer.
- Full stall: producer 2 granted; `full`=1 for 3 cycles after the 2nd beat:
  - `w_en`=0 and `grant` held during the stall;
  - beats 3–4 complete after `full` drops;
  - 4 total writes, no duplicates.
- Early release: producer 1 drops `req` after 2 beats:
  - `grant`=0 on the next edge;
  - 2 writes only;
  - `last`=1, so a pending producer 2 wins next over producer 0.
- Reset mid-burst, asserted at beat 2:
  - `w_en`=0 during the reset cycle;
  - `grant`=0, `busy`=0 after the edge;
  - next arbitration with `req`=1111 grants producer 0.
- `N`=2, `Burst`=1, `req`=11: grants alternate 0,1,0,1, one write each, idle cycle between.
